pid: RTL and testbench
======================

// Module: pid
// PURPOSE
//  Output stage of the PID controller: combines the proportional, integral and
//  derivative contributions into one saturated, registered control variable u.
//  Integrates the I contribution into an accumulator with anti-windup clamping,
//  and differences the D contribution against its previous sample.
//  Sits between the error/gain scaling stages and the actuator interface.
// PARAMETERS
//  IN_W   6  width of each signed contribution input (two's complement)
//  OUT_W  8  width of signed output u and of the integral accumulator
// PORTS
//  clk        in   1      system clock; all state updates on rising edge
//  rst_n      in   1      synchronous active-low reset
//  ena        in   1      update enable; 0 = hold all state
//  p_contrib  in   IN_W   signed proportional contribution
//  i_contrib  in   IN_W   signed integral increment
//  d_contrib  in   IN_W   signed derivative-path sample
//  u          out  OUT_W  signed control variable, registered
//  sat        out  1      1 when the last update of u was clamped
// BEHAVIOUR
//  Interface: one clock domain (clk); reset is synchronous, active-low (rst_n).
//  Reset (rst_n=0 at posedge): u=0, sat=0, integ=0, d_prev=0; takes priority over ena.
//  State: integ (OUT_W signed), d_prev (IN_W signed), u, sat.
//  On posedge with rst_n=1, ena=1:
//   - integ_n = clamp_OUT(integ + sext(i_contrib))
//   - ddiff   = sext(d_contrib) - sext(d_prev)   (IN_W+1 bits, no overflow)
//   - sum     = sext(p_contrib) + integ_n + ddiff (computed at OUT_W+2 bits)
//   - u <= clamp_OUT(sum); sat <= (sum outside OUT_W range)
//   - integ <= integ_n; d_prev <= d_contrib
//  clamp_OUT: limits to [-2^(OUT_W-1), 2^(OUT_W-1)-1] (-128..127 default);
//   never wraps. Integrator clamping is anti-windup; it does not set sat.
//  ena=0: u, sat, integ, d_prev all hold; inputs ignored.
//  Latency: 1 cycle from inputs to u. No handshake; inputs sampled every enabled edge.
//  Inputs treated as signed; all extensions are sign extensions.
//  First enabled cycle after reset differentiates against d_prev=0.
//  Reset mid-operation clears accumulator and derivative history in the same cycle.
// TESTING
//  1 reset, ena=1, p=31,i=1,d=1 (6'h1F,01,01): cycle1 u=33 (8'h21), sat=0;
//    cycle2 same inputs u=33 (integ=2, ddiff=0).
//  2 reset, ena=1, p=i=d=-32 (6'h20): u sequence -96,-96,-128 (8'hA0,A0,80);
//    4th cycle integ pinned -128, sum=-160 -> u=-128, sat=1.
//  3 reset, ena=1, p=i=d=-1 (6'h3F) one cycle: u=-3 (8'hFD), sat=0.
//  4 mid-run drop ena=0 and change inputs: u, sat unchanged; re-enable resumes from held integ/d_prev.
//  5 assert rst_n=0 one cycle mid-run with ena=1: u=0, sat=0 next cycle; next enabled
//    cycle with p=0,i=0,d=5 gives u=5.
//  6 integrator windup: i=31,p=0,d=0 for 6 cycles -> integ and u saturate at 127, then
//    i=-31 one cycle -> u=96 immediately (no windup delay).

Source files
------------

// File: rtl/pid.sv
// PID output stage: integrates I with anti-windup, differences D, and
// produces a saturated, registered control variable u with a clamp flag.
module pid #(
  parameter int unsigned IN_W  = 6,
  parameter int unsigned OUT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic signed [IN_W-1:0]  p_contrib,
  input  logic signed [IN_W-1:0]  i_contrib,
  input  logic signed [IN_W-1:0]  d_contrib,
  output logic signed [OUT_W-1:0] u,
  output logic                    sat
);

  localparam int unsigned ACC_W = OUT_W + 1;
  localparam int unsigned DIF_W = IN_W + 1;
  localparam int unsigned SUM_W = OUT_W + 2;
  localparam int unsigned HI_W  = SUM_W - OUT_W + 1;

  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [OUT_W-1:0] integ_q, integ_d;
  logic signed [IN_W-1:0]  d_prev_q, d_prev_d;
  logic signed [OUT_W-1:0] u_q, u_d;
  logic                    sat_q, sat_d;

  logic signed [ACC_W-1:0] acc_sum;
  logic signed [DIF_W-1:0] ddiff;
  logic signed [SUM_W-1:0] sum;
  logic        [HI_W-1:0]  sum_hi;
  logic                    sum_fits;

  // Next-state datapath: clamped integrator, derivative difference, output sum.
  always_comb begin
    integ_d  = integ_q;
    d_prev_d = d_contrib;
    u_d      = u_q;
    sat_d    = sat_q;

    acc_sum = ACC_W'(integ_q) + ACC_W'(i_contrib);
    if (acc_sum[ACC_W-1] != acc_sum[ACC_W-2]) begin
      integ_d = acc_sum[ACC_W-1] ? OUT_MIN : OUT_MAX;
    end else begin
      integ_d = acc_sum[OUT_W-1:0];
    end

    ddiff = DIF_W'(d_contrib) - DIF_W'(d_prev_q);
    sum   = SUM_W'(p_contrib) + SUM_W'(integ_d) + SUM_W'(ddiff);

    // Sum fits OUT_W only when every bit above the OUT_W sign bit matches it.
    sum_hi   = sum[SUM_W-1:OUT_W-1];
    sum_fits = (&sum_hi) | ~(|sum_hi);
    sat_d    = ~sum_fits;
    if (sum_fits) begin
      u_d = sum[OUT_W-1:0];
    end else begin
      u_d = sum[SUM_W-1] ? OUT_MIN : OUT_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      integ_q  <= '0;
      d_prev_q <= '0;
      u_q      <= '0;
      sat_q    <= 1'b0;
    end else if (ena) begin
      integ_q  <= integ_d;
      d_prev_q <= d_prev_d;
      u_q      <= u_d;
      sat_q    <= sat_d;
    end
  end

  assign u   = u_q;
  assign sat = sat_q;

endmodule

// File: tb/tb_pid.sv
// Self-checking bench for pid: randomized stimulus against an integer model,
// plus hand-computed expectations for the directed scenarios.
module tb_pid;

  logic              clk;
  logic              rst_n;
  logic              ena;
  logic signed [5:0] p_contrib;
  logic signed [5:0] i_contrib;
  logic signed [5:0] d_contrib;
  logic signed [7:0] u;
  logic              sat;

  pid #(.IN_W(6), .OUT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .p_contrib (p_contrib),
    .i_contrib (i_contrib),
    .d_contrib (d_contrib),
    .u         (u),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  bit started  = 1'b0;

  bit lit_valid = 1'b0;
  int lit_u     = 0;
  bit lit_sat   = 1'b0;
  string lit_name = "";

  int m_integ = 0;
  int m_dprev = 0;
  int m_u     = 0;
  bit m_sat   = 1'b0;

  function automatic int clamp8(input int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  // Reference model: plain integer arithmetic, updated on each rising edge.
  initial begin
    int ni, s;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_integ = 0; m_dprev = 0; m_u = 0; m_sat = 1'b0;
      end else if (ena) begin
        ni = clamp8(m_integ + int'(i_contrib));
        s  = int'(p_contrib) + ni + (int'(d_contrib) - m_dprev);
        m_u     = clamp8(s);
        m_sat   = (s > 127) || (s < -128);
        m_integ = ni;
        m_dprev = int'(d_contrib);
      end
    end
  end

  // Compare process: model check every cycle, plus literal checks when posted.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        n_checks++;
        if ($isunknown(u) || int'(u) != m_u) begin
          n_fails++;
          $display("FAIL model_u t=%0t got %0d expected %0d", $time, u, m_u);
        end
        n_checks++;
        if ($isunknown(sat) || sat != m_sat) begin
          n_fails++;
          $display("FAIL model_sat t=%0t got %0b expected %0b", $time, sat, m_sat);
        end
        if (lit_valid) begin
          n_checks++;
          if ($isunknown(u) || int'(u) != lit_u || sat != lit_sat) begin
            n_fails++;
            $display("FAIL %s got u=%0d sat=%0b expected u=%0d sat=%0b",
                     lit_name, u, sat, lit_u, lit_sat);
          end
        end
      end
    end
  end

  task automatic apply(input bit r, input bit e, input int p, input int i, input int d);
    rst_n     = r;
    ena       = e;
    p_contrib = 6'(p);
    i_contrib = 6'(i);
    d_contrib = 6'(d);
    @(posedge clk);
    #2;
  endtask

  task automatic expect_lit(input string name, input int eu, input bit es);
    lit_name  = name;
    lit_u     = eu;
    lit_sat   = es;
    lit_valid = 1'b1;
    @(negedge clk);
    #1;
    lit_valid = 1'b0;
  endtask

  initial begin
    int seq2 [4] = '{-96, -96, -128, -128};
    int seq6 [6] = '{31, 62, 93, 124, 127, 127};
    int p, i, d;
    bit e, r;

    rst_n = 1'b0; ena = 1'b0; p_contrib = '0; i_contrib = '0; d_contrib = '0;
    apply(0, 0, 0, 0, 0);
    apply(0, 1, 5, 5, 5);
    started = 1'b1;
    expect_lit("reset", 0, 1'b0);

    apply(1, 1, 31, 1, 1);
    expect_lit("t1_c1", 33, 1'b0);
    apply(1, 1, 31, 1, 1);
    expect_lit("t1_c2", 33, 1'b0);

    apply(0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      apply(1, 1, -32, -32, -32);
      expect_lit($sformatf("t2_c%0d", k + 1), seq2[k], k == 3);
    end

    apply(0, 1, 0, 0, 0);
    apply(1, 1, -1, -1, -1);
    expect_lit("t3_neg1", -3, 1'b0);

    apply(0, 1, 0, 0, 0);
    apply(1, 1, 0, 10, 3);
    expect_lit("t4_run", 13, 1'b0);
    apply(1, 0, 20, 20, 20);
    expect_lit("t4_hold1", 13, 1'b0);
    apply(1, 0, -30, 31, -7);
    expect_lit("t4_hold2", 13, 1'b0);
    apply(1, 1, 0, 10, 3);
    expect_lit("t4_resume", 20, 1'b0);

    apply(0, 1, 5, 5, 5);
    expect_lit("t5_reset", 0, 1'b0);
    apply(1, 1, 0, 0, 5);
    expect_lit("t5_after", 5, 1'b0);

    apply(0, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      apply(1, 1, 0, 31, 0);
      expect_lit($sformatf("t6_wind%0d", k + 1), seq6[k], 1'b0);
    end
    apply(1, 1, 0, -31, 0);
    expect_lit("t6_unwind", 96, 1'b0);

    // Randomized phase, biased toward extreme integrator increments.
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 99) >= 3);
      e = ($urandom_range(0, 99) >= 20);
      p = $urandom_range(0, 63) - 32;
      d = $urandom_range(0, 63) - 32;
      if ($urandom_range(0, 3) == 0) i = ($urandom_range(0, 1) == 1) ? 31 : -32;
      else i = $urandom_range(0, 63) - 32;
      apply(r, e, p, i, d);
    end

    apply(1, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
